// File: rtl/avr_serial_pkg.sv
// ---------------------------------------------------------------------------
// avr_serial_pkg
// Shared definitions for the FPGA-to-AVR serial link.
//   - tx_state_t : transmitter FSM states (PARITY is used only when the
//                  AVR_SERIAL_TX_PARITY_EN macro is defined)
//   - DEF_CLK_PER_BIT : default clk cycles per serial bit (50 MHz / 500 kbaud)
//   - DEF_FIFO_DEPTH  : default byte FIFO depth
//   - IDLE_LEVEL      : level of the serial line between frames
// ---------------------------------------------------------------------------
package avr_serial_pkg;

    localparam int   DEF_CLK_PER_BIT = 100;
    localparam int   DEF_FIFO_DEPTH  = 16;
    localparam logic IDLE_LEVEL      = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo_8.sv
// ---------------------------------------------------------------------------
// sync_fifo_8
// Single-clock byte FIFO, shared by the Tx and Rx halves of the AVR link.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (empties the FIFO)
//   push       : write push_data this edge (ignored when full)
//   push_data  : byte to write
//   pop        : advance the read pointer this edge (ignored when empty)
//   pop_data   : current head byte, valid whenever empty == 0
//   full/empty : derived from the registered occupancy count
//   count      : bytes currently stored
// The head is read combinationally so a consumer can load it and pop in the
// same cycle; at these depths the array maps to distributed RAM.
// DEPTH must be a power of two (pointers wrap naturally), minimum 2.
// ---------------------------------------------------------------------------
module sync_fifo_8 #(
    parameter int DEPTH = 16,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             wr_en;
    logic             rd_en;

    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    // Storage carries no reset: stale bytes are unreachable once the
    // pointers and count are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr_reg];
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;

endmodule

// File: rtl/avr_serial_tx.sv
// ---------------------------------------------------------------------------
// avr_serial_tx
// Transmit half of the FPGA-to-AVR serial link. Bytes arrive over a
// valid/ready interface, are buffered in sync_fifo_8, and are sent 8N1,
// LSB first, on tx. A new frame is started only while the AVR's Rx-buffer-
// full flag (rx_busy, synchronised) is low; a frame in flight always runs
// to completion.
// Ports:
//   clk, rst   : 50 MHz clock, asynchronous active-high reset
//   in_data    : byte to send
//   in_valid   : in_data valid; accepted on an edge where in_ready is high
//   in_ready   : FIFO not full (from registered count only)
//   tx         : serial line to AVR Rx, idle high, driven from a flop
//   rx_busy    : AVR Rx buffer full, asynchronous to clk
//   busy       : frame in flight or FIFO non-empty
//   fifo_count : bytes currently buffered
// Build option: define AVR_SERIAL_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11-bit frames).
// ---------------------------------------------------------------------------
module avr_serial_tx
    import avr_serial_pkg::*;
#(
    parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx,
    input  logic             rx_busy,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count
);

    localparam int                   BIT_CNT_W = $clog2(CLK_PER_BIT);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(CLK_PER_BIT - 1);

    tx_state_t            state_reg,   state_next;
    logic [BIT_CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [2:0]           bit_idx_reg, bit_idx_next;
    logic [7:0]           shift_reg,   shift_next;
    logic                 tx_reg,      tx_next;
    logic                 busy_meta_reg;
    logic                 busy_s_reg;
`ifdef AVR_SERIAL_TX_PARITY_EN
    logic                 parity_reg,  parity_next;
`endif

    logic       fifo_pop;
    logic [7:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       bit_done;

    sync_fifo_8 #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (in_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Two-flop synchroniser; resets to "busy" so nothing is sent until the
    // AVR's flag has actually been sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_meta_reg <= 1'b1;
            busy_s_reg    <= 1'b1;
        end else begin
            busy_meta_reg <= rx_busy;
            busy_s_reg    <= busy_meta_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= IDLE_LEVEL;
`ifdef AVR_SERIAL_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
`ifdef AVR_SERIAL_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end

    assign bit_done = (bit_cnt_reg == BIT_LAST);

    // tx_next is the line level for the current state; registering it puts
    // tx one cycle behind the state, which gives the push->start latency of
    // two edges and a glitch-free line.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        tx_next      = IDLE_LEVEL;
        fifo_pop     = 1'b0;
`ifdef AVR_SERIAL_TX_PARITY_EN
        parity_next  = parity_reg;
`endif

        if (state_reg != IDLE) begin
            bit_cnt_next = bit_done ? '0 : bit_cnt_reg + BIT_CNT_W'(1);
        end

        case (state_reg)
            IDLE: begin
                bit_cnt_next = '0;
                bit_idx_next = '0;
                // The AVR flag is honoured only here, so a frame in flight
                // is never cut short.
                if (!fifo_empty && !busy_s_reg) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_head;
`ifdef AVR_SERIAL_TX_PARITY_EN
                    parity_next = ^fifo_head;
`endif
                    state_next = START;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (bit_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_next = shift_reg[0];
                if (bit_done) begin
                    shift_next   = shift_reg >> 1;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
`ifdef AVR_SERIAL_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef AVR_SERIAL_TX_PARITY_EN
            PARITY: begin
                tx_next = parity_reg;
                if (bit_done) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                tx_next = IDLE_LEVEL;
                if (bit_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign tx       = tx_reg;
    assign in_ready = !fifo_full;
    assign busy     = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_avr_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_avr_serial_tx
// Stimulus pushes bytes into avr_serial_tx and queues the expected byte; an
// independent monitor decodes frames from the tx line by mid-bit sampling
// and compares each against the head of the queue.
// ---------------------------------------------------------------------------
module tb_avr_serial_tx;

    localparam int CPB   = 100;
    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef AVR_SERIAL_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // one frame plus the single IDLE cycle between frames
    localparam int FRAME_CYC = FRAME_BITS * CPB + 1;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic [7:0]       in_data  = 8'h00;
    logic             in_valid = 1'b0;
    logic             rx_busy  = 1'b0;
    logic             in_ready;
    logic             tx;
    logic             busy;
    logic [CNT_W-1:0] fifo_count;

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    int          frames_seen = 0;
    byte unsigned exp_q[$];
    bit          mon_en  = 1'b1;
    bit          gap_chk = 1'b0;

    avr_serial_tx #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .rx_busy    (rx_busy),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Called just after a negedge; presents the byte across one posedge.
    task automatic send(input logic [7:0] b, input bit track);
        in_valid = 1'b1;
        in_data  = b;
        if (in_ready && track) exp_q.push_back(b);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic wait_drained(input string name, input int budget);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_timeout"}, int'(n < budget), 1);
        check({name, "_busy"}, busy, 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        int           last_start;
        int           t0;
        logic [7:0]   got;
        logic         sbit;
        logic         pbit;
        logic         stbit;
        byte unsigned want;
        last_start = -1;
        pbit       = 1'b0;
        forever begin
            @(negedge clk);
            if (!gap_chk) last_start = -1;
            if (mon_en && !rst && tx == 1'b0) begin
                t0 = cyc;
                if (gap_chk && last_start >= 0)
                    check("frame_gap", t0 - last_start, FRAME_CYC);
                last_start = t0;
                repeat (CPB / 2) @(negedge clk);
                sbit = tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    got[i] = tx;
                end
`ifdef AVR_SERIAL_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                pbit = tx;
`endif
                repeat (CPB) @(negedge clk);
                stbit = tx;
                frames_seen++;
                check("start_bit", sbit, 0);
                check("stop_bit", stbit, 1);
                if (exp_q.size() == 0) begin
                    check("frame_expected", exp_q.size(), 1);
                end else begin
                    want = exp_q.pop_front();
                    $display("frame %0d at cycle %0d: byte 0x%02h, expected 0x%02h",
                             frames_seen, t0, got, want);
                    check("data_byte", got, want);
`ifdef AVR_SERIAL_TX_PARITY_EN
                    check("parity_bit", pbit, $countones(want) % 2);
`endif
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #(95000 * 10);
        $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int n;
        int lows;
        bit acc_exp;

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_in_ready", in_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_fifo_count", fifo_count, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single byte latency, bit pattern (monitor), busy release
        send(8'h55, 1'b1);                 // now just past edge N
        check("lat_tx_edge_n", tx, 1);
        @(negedge clk);
        check("lat_tx_edge_n1", tx, 1);
        @(negedge clk);
        check("lat_tx_edge_n2", tx, 0);
        repeat (FRAME_CYC - 3) @(negedge clk);
        check("busy_before_end", busy, 1);
        @(negedge clk);
        check("busy_after_frame", busy, 0);
        repeat (50) @(negedge clk);

        // 2: fill the FIFO while the AVR reports busy
        rx_busy = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < DEPTH + 1; i++) begin
            acc_exp = (i < DEPTH);
            check("in_ready_fill", in_ready, int'(acc_exp));
            send(8'($urandom), 1'b1);
        end
        check("full_count", fifo_count, DEPTH);
        check("full_in_ready", in_ready, 0);
        check("full_queue_len", exp_q.size(), DEPTH);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        check("held_tx_idle", lows, 0);

        // 3: release; 16 back-to-back frames, in order
        gap_chk = 1'b1;
        rx_busy = 1'b0;
        n = 0;
        while (tx == 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("release_start_cycles", n, 4);
        wait_drained("burst", (DEPTH + 1) * FRAME_CYC + 100);
        gap_chk = 1'b0;
        repeat (20) @(negedge clk);

        // 4: rx_busy raised mid-data holds the following byte
        send(8'hA3, 1'b1);
        send(8'($urandom), 1'b1);
        repeat (398) @(negedge clk);
        rx_busy = 1'b1;
        repeat (FRAME_CYC + 300) @(negedge clk);
        check("hold_fifo_count", fifo_count, 1);
        check("hold_tx", tx, 1);
        check("hold_queue_len", exp_q.size(), 1);
        rx_busy = 1'b0;
        wait_drained("hold", 2 * FRAME_CYC + 100);
        repeat (20) @(negedge clk);

        // 5: reset during data bit 4 with bytes queued
        mon_en = 1'b0;
        send(8'h00, 1'b0);
        for (int i = 0; i < 4; i++) send(8'($urandom), 1'b0);
        repeat (548) @(negedge clk);
        check("pre_reset_tx_low", tx, 0);
        rst = 1'b1;
        #1;
        check("reset_tx_async", tx, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_count", fifo_count, 0);
        check("post_reset_in_ready", in_ready, 1);
        check("post_reset_busy", busy, 0);
        lows = 0;
        for (int i = 0; i < 2 * FRAME_CYC; i++) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        check("post_reset_no_frames", lows, 0);
        mon_en = 1'b1;

        // 6: random bytes, random gaps and random AVR busy pulses
`ifdef AVR_SERIAL_TX_PARITY_EN
        send(8'h07, 1'b1);
        send(8'h03, 1'b1);
`endif
        for (int i = 0; i < 8; i++) begin
            send(8'($urandom), 1'b1);
            rx_busy = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 1500)) @(negedge clk);
            rx_busy = 1'b0;
        end
        wait_drained("random", 12 * FRAME_CYC + 100);
        check("frames_total", frames_seen, 1 + DEPTH + 2 + 8
`ifdef AVR_SERIAL_TX_PARITY_EN
              + 2
`endif
              );

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
